ud_counter_bank: RTL and testbench

//  Bank of NCH independent up/down counter SFRs, each SIZE bits wide, with a load port.

---
 rtl/ud_counter_bank_pkg.sv | 9 +
 rtl/ud_counter_ch.sv | 69 ++++++
 rtl/ud_counter_bank.sv | 53 +++++
 tb/tb_ud_counter_bank.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ud_counter_bank_pkg.sv
// Shared definitions for the up/down counter bank: counting modes latched at load time.
package ud_counter_bank_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage

// File: rtl/ud_counter_ch.sv
// One counter channel: count, mode, sticky overflow/underflow.
// Priority per clock: load > (incr & decr) > incr > decr > hold.
module ud_counter_ch
    import ud_counter_bank_pkg::*;
#(
    parameter int SIZE = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_this,
    input  logic [SIZE-1:0] ld_val,
    input  logic            ld_mode,
    input  logic            incr,
    input  logic            decr,
    input  logic            clr_stat,
    output logic [SIZE-1:0] q,
    output logic            ovf,
    output logic            unf
);

    localparam logic [SIZE-1:0] MAXV = '1;

    mode_e           mode, mode_next;
    logic [SIZE-1:0] q_next;
    logic            set_ovf, set_unf;

    always_comb begin
        q_next    = q;
        mode_next = mode;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        if (ld_this) begin
            q_next    = ld_val;
            mode_next = mode_e'(ld_mode);
        end else if (incr && decr) begin
            q_next = q;
        end else if (incr) begin
            if (q == MAXV) begin
                set_ovf = 1'b1;
                q_next  = (mode == MODE_SAT) ? MAXV : '0;
            end else begin
                q_next = q + 1'b1;
            end
        end else if (decr) begin
            if (q == '0) begin
                set_unf = 1'b1;
                q_next  = (mode == MODE_SAT) ? '0 : MAXV;
            end else begin
                q_next = q - 1'b1;
            end
        end
    end

    // A set event in the same cycle as a clear leaves the sticky bit high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            mode <= MODE_WRAP;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            q    <= q_next;
            mode <= mode_next;
            ovf  <= set_ovf | (ovf & ~clr_stat);
            unf  <= set_unf | (unf & ~clr_stat);
        end
    end

endmodule

// File: rtl/ud_counter_bank.sv
// Bank of NCH independent up/down counters with a shared load port
// and per-channel zero/max decode of the registered counts.
module ud_counter_bank
    import ud_counter_bank_pkg::*;
#(
    parameter int SIZE = 5,
    parameter int NCH  = 4,
    parameter int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld,
    input  logic [CH_W-1:0]     ld_ch,
    input  logic [SIZE-1:0]     ld_val,
    input  logic                ld_mode,
    input  logic [NCH-1:0]      incr,
    input  logic [NCH-1:0]      decr,
    input  logic [NCH-1:0]      clr_stat,
    output logic [NCH*SIZE-1:0] Q,
    output logic [NCH-1:0]      zero,
    output logic [NCH-1:0]      max,
    output logic [NCH-1:0]      ovf,
    output logic [NCH-1:0]      unf
);

    // Select values at or beyond NCH match no channel, so such loads vanish.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam logic [CH_W-1:0] CH_IDX = CH_W'(i);

        logic [SIZE-1:0] q_ch;

        ud_counter_ch #(
            .SIZE(SIZE)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .ld_this (ld && (ld_ch == CH_IDX)),
            .ld_val  (ld_val),
            .ld_mode (ld_mode),
            .incr    (incr[i]),
            .decr    (decr[i]),
            .clr_stat(clr_stat[i]),
            .q       (q_ch),
            .ovf     (ovf[i]),
            .unf     (unf[i])
        );

        assign Q[i*SIZE +: SIZE] = q_ch;
        assign zero[i]           = (q_ch == '0);
        assign max[i]            = (q_ch == '1);
    end

endmodule

// File: tb/tb_ud_counter_bank.sv
// Self-checking bench for ud_counter_bank: directed vector table, reset and
// out-of-range corner cases, then random strobes against a behavioural model.
module tb_ud_counter_bank;

    localparam int SIZE = 5;
    localparam int NCH  = 4;
    localparam int MAXV = (1 << SIZE) - 1;

    logic                clk;
    logic                rst_n;
    logic                ld;
    logic [1:0]          ld_ch;
    logic [SIZE-1:0]     ld_val;
    logic                ld_mode;
    logic [NCH-1:0]      incr, decr, clr_stat;
    logic [NCH*SIZE-1:0] Q;
    logic [NCH-1:0]      zero, max, ovf, unf;

    // Three-channel instance used only to show that ld_ch == 3 is ignored.
    logic                ld3;
    logic [1:0]          ld3_ch;
    logic [SIZE-1:0]     ld3_val;
    logic [3*SIZE-1:0]   q3;
    logic [2:0]          z3, m3, o3, u3;

    int checks = 0;
    int errors = 0;

    int refQ[NCH];
    bit refSat[NCH];
    bit refOvf[NCH];
    bit refUnf[NCH];

    typedef struct {
        logic       ld;
        logic [1:0] ch;
        logic [4:0] val;
        logic       mode;
        logic [3:0] inc;
        logic [3:0] dec;
        logic [3:0] clr;
        int         expCh;
        int         expQ;
        bit         expOvf;
        bit         expUnf;
    } vec_t;

    vec_t vecs[19];

    ud_counter_bank #(.SIZE(SIZE), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .ld(ld), .ld_ch(ld_ch), .ld_val(ld_val),
        .ld_mode(ld_mode), .incr(incr), .decr(decr), .clr_stat(clr_stat),
        .Q(Q), .zero(zero), .max(max), .ovf(ovf), .unf(unf)
    );

    ud_counter_bank #(.SIZE(SIZE), .NCH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ld(ld3), .ld_ch(ld3_ch), .ld_val(ld3_val),
        .ld_mode(1'b0), .incr(3'b000), .decr(3'b000), .clr_stat(3'b000),
        .Q(q3), .zero(z3), .max(m3), .ovf(o3), .unf(u3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < NCH; i++) begin
            refQ[i] = 0; refSat[i] = 0; refOvf[i] = 0; refUnf[i] = 0;
        end
    endtask

    // Behavioural channel rules in plain integer arithmetic.
    task automatic modelStep();
        for (int i = 0; i < NCH; i++) begin
            bit setO, setU;
            setO = 0; setU = 0;
            if (ld && int'(ld_ch) == i) begin
                refQ[i]   = int'(ld_val);
                refSat[i] = ld_mode;
            end else if (incr[i] && decr[i]) begin
                setO = 0;
            end else if (incr[i]) begin
                if (refQ[i] == MAXV) begin
                    setO = 1;
                    refQ[i] = refSat[i] ? MAXV : 0;
                end else refQ[i] = refQ[i] + 1;
            end else if (decr[i]) begin
                if (refQ[i] == 0) begin
                    setU = 1;
                    refQ[i] = refSat[i] ? 0 : MAXV;
                end else refQ[i] = refQ[i] - 1;
            end
            refOvf[i] = setO || (refOvf[i] && !clr_stat[i]);
            refUnf[i] = setU || (refUnf[i] && !clr_stat[i]);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [NCH*SIZE-1:0] eq;
        logic [NCH-1:0] ez, em, eo, eu;
        for (int i = 0; i < NCH; i++) begin
            eq[i*SIZE +: SIZE] = SIZE'(refQ[i]);
            ez[i] = (refQ[i] == 0);
            em[i] = (refQ[i] == MAXV);
            eo[i] = refOvf[i];
            eu[i] = refUnf[i];
        end
        check({tag, ".Q"},    32'(Q),    32'(eq));
        check({tag, ".zero"}, 32'(zero), 32'(ez));
        check({tag, ".max"},  32'(max),  32'(em));
        check({tag, ".ovf"},  32'(ovf),  32'(eo));
        check({tag, ".unf"},  32'(unf),  32'(eu));
    endtask

    // Drive at the negedge, let one posedge act, settle back at the negedge.
    task automatic applyStimulus(input logic l, input logic [1:0] c, input logic [4:0] v,
                                 input logic m, input logic [3:0] inc, input logic [3:0] dec,
                                 input logic [3:0] clr);
        ld = l; ld_ch = c; ld_val = v; ld_mode = m;
        incr = inc; decr = dec; clr_stat = clr;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        ld = 0; incr = '0; decr = '0; clr_stat = '0;
    endtask

    initial begin
        // {ld, ch, val, mode, incr, decr, clr, channel, Q, ovf, unf}
        vecs[0]  = '{1, 1, 30, 0, 4'h0, 4'h0, 4'h0, 1, 30, 0, 0};
        vecs[1]  = '{0, 0,  0, 0, 4'h2, 4'h0, 4'h0, 1, 31, 0, 0};
        vecs[2]  = '{0, 0,  0, 0, 4'h2, 4'h0, 4'h0, 1,  0, 1, 0};
        vecs[3]  = '{0, 0,  0, 0, 4'h2, 4'h0, 4'h0, 1,  1, 1, 0};
        vecs[4]  = '{1, 2,  1, 1, 4'h0, 4'h0, 4'h0, 2,  1, 0, 0};
        vecs[5]  = '{0, 0,  0, 0, 4'h0, 4'h4, 4'h0, 2,  0, 0, 0};
        vecs[6]  = '{0, 0,  0, 0, 4'h0, 4'h4, 4'h0, 2,  0, 0, 1};
        vecs[7]  = '{0, 0,  0, 0, 4'h0, 4'h4, 4'h0, 2,  0, 0, 1};
        vecs[8]  = '{1, 0,  7, 0, 4'h0, 4'h0, 4'h0, 0,  7, 0, 0};
        vecs[9]  = '{0, 0,  0, 0, 4'h1, 4'h1, 4'h0, 0,  7, 0, 0};
        vecs[10] = '{1, 0, 12, 0, 4'h1, 4'h0, 4'h0, 0, 12, 0, 0};
        vecs[11] = '{1, 3, 31, 0, 4'h0, 4'h0, 4'h0, 3, 31, 0, 0};
        vecs[12] = '{0, 0,  0, 0, 4'h8, 4'h0, 4'h0, 3,  0, 1, 0};
        vecs[13] = '{0, 0,  0, 0, 4'h0, 4'h0, 4'h8, 3,  0, 0, 0};
        vecs[14] = '{1, 3, 31, 1, 4'h0, 4'h0, 4'h0, 3, 31, 0, 0};
        vecs[15] = '{0, 0,  0, 0, 4'h8, 4'h0, 4'h8, 3, 31, 1, 0};
        vecs[16] = '{0, 0,  0, 0, 4'h0, 4'h0, 4'h2, 1,  1, 0, 0};
        vecs[17] = '{0, 0,  0, 0, 4'h0, 4'h2, 4'h0, 1,  0, 0, 0};
        vecs[18] = '{0, 0,  0, 0, 4'h0, 4'h2, 4'h0, 1, 31, 0, 1};

        rst_n = 0; ld = 0; ld_ch = 0; ld_val = 0; ld_mode = 0;
        incr = 0; decr = 0; clr_stat = 0;
        ld3 = 0; ld3_ch = 0; ld3_val = 0;
        resetModel();
        repeat (2) @(negedge clk);
        check("reset.Q", 32'(Q), 32'h0);
        check("reset.zero", 32'(zero), 32'hF);
        check("reset.max", 32'(max), 32'h0);
        rst_n = 1;

        // Count up a few cycles, then pull reset in the middle of a clock high phase.
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 4'hF, 4'h0, 4'h0);
        checkOutput("preReset");
        incr = 4'hF;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        resetModel();
        checkOutput("asyncReset");
        @(posedge clk);
        #1 checkOutput("heldReset");
        @(negedge clk);
        incr = 0;
        rst_n = 1;

        $display("[TB] directed vector table");
        foreach (vecs[n]) begin
            applyStimulus(vecs[n].ld, vecs[n].ch, vecs[n].val, vecs[n].mode,
                          vecs[n].inc, vecs[n].dec, vecs[n].clr);
            check($sformatf("vec%0d.Q", n), 32'(Q[vecs[n].expCh*SIZE +: SIZE]), 32'(vecs[n].expQ));
            check($sformatf("vec%0d.ovf", n), 32'(ovf[vecs[n].expCh]), 32'(vecs[n].expOvf));
            check($sformatf("vec%0d.unf", n), 32'(unf[vecs[n].expCh]), 32'(vecs[n].expUnf));
            checkOutput($sformatf("vec%0d", n));
        end
        check("vec1.maxSeen", 32'(max[1]), 32'h1);

        $display("[TB] out-of-range load on 3-channel bank");
        ld3 = 1; ld3_ch = 0; ld3_val = 5;
        @(negedge clk);
        ld3_ch = 3; ld3_val = 9;
        repeat (3) @(negedge clk);
        ld3 = 0;
        check("oor.Q", 32'(q3), 32'h5);
        check("oor.zero", 32'(z3), 32'h6);

        $display("[TB] random strobes against model");
        for (int k = 0; k < 1000; k++) begin
            applyStimulus(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                          5'($urandom_range(0, MAXV)), 1'($urandom_range(0, 1)),
                          4'($urandom), 4'($urandom),
                          4'($urandom) & 4'($urandom));
            checkOutput($sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
